// File: rtl/twbit_serial_sub_if.sv
// Handshake and operand/result bundle for the 12-bit bit-serial subtractor.
interface twbit_serial_sub_if;
  localparam int unsigned W = 12;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         borrow;
  logic         busy;
  logic         done;

  modport master (
    output start, a, b,
    input  c, borrow, busy, done
  );

  modport slave (
    input  start, a, b,
    output c, borrow, busy, done
  );
endinterface

// File: rtl/twbit_serial_sub.sv
// Sequential 12-bit bit-serial subtractor: c = a - b, LSB first, one
// full-subtractor cell and a registered borrow, framed by start/busy/done.
// Optional build macro TWBIT_SUB_SATURATE_EN clamps underflowing results to 0.
module twbit_serial_sub (
  input  logic               clk,
  input  logic               rst,
  twbit_serial_sub_if.slave  bus
);
  localparam int unsigned W  = 12;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  sa, sa_n;
  logic [W-1:0]  sb, sb_n;
  logic [W-1:0]  sr, sr_n;
  logic          bw, bw_n;
  logic [W-1:0]  c_q, c_n;
  logic          borrow_q, borrow_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic          d;
  logic          bstep;
  logic [W-1:0]  diff;

  // State, datapath and registered outputs; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      bw       <= 1'b0;
      c_q      <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sa       <= sa_n;
      sb       <= sb_n;
      sr       <= sr_n;
      bw       <= bw_n;
      c_q      <= c_n;
      borrow_q <= borrow_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  // Next-state, bit step and output update.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sa_n     = sa;
    sb_n     = sb;
    sr_n     = sr;
    bw_n     = bw;
    c_n      = c_q;
    borrow_n = borrow_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    d        = sa[0] ^ sb[0] ^ bw;
    bstep    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw);
    diff     = {d, sr[W-1:1]};

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = RUN;
          sa_n    = bus.a;
          sb_n    = bus.b;
          bw_n    = 1'b0;
          cnt_n   = '0;
          busy_n  = 1'b1;
        end
      end
      RUN: begin
        sa_n  = {1'b0, sa[W-1:1]};
        sb_n  = {1'b0, sb[W-1:1]};
        sr_n  = diff;
        bw_n  = bstep;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          state_n  = DONE;
`ifdef TWBIT_SUB_SATURATE_EN
          c_n      = bstep ? '0 : diff;
`else
          c_n      = diff;
`endif
          borrow_n = bstep;
          busy_n   = 1'b0;
          done_n   = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.c      = c_q;
  assign bus.borrow = borrow_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_twbit_serial_sub.sv
// Directed self-checking bench for twbit_serial_sub.
module tb_twbit_serial_sub;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  twbit_serial_sub_if bus ();

  twbit_serial_sub dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result expected in this build from a hand-computed wrapped value.
  function automatic logic [11:0] exp_c(input logic [11:0] cw, input logic bor);
`ifdef TWBIT_SUB_SATURATE_EN
    return bor ? 12'h000 : cw;
`else
    return cw;
`endif
  endfunction

  // Drive one operation and observe it from E+0.5 to E+13.5 (returns at E+13.5).
  task automatic run_op(input logic [11:0] av, input logic [11:0] bv, input bit scramble,
                        output logic [11:0] oc, output logic ob, output int busy_n,
                        output int done_n, output bit stable, output bit at12);
    logic [11:0] prev;
    @(negedge clk);
    bus.start = 1'b1; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0;
    prev = bus.c; busy_n = 0; done_n = 0; stable = 1'b1; at12 = 1'b0;
    oc = 'x; ob = 1'bx;
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) @(negedge clk);
      if (scramble) begin
        bus.a = 12'($urandom);
        bus.b = 12'($urandom);
      end
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) done_n++;
      if (k < 12 && bus.c !== prev) stable = 1'b0;
      if (k == 12) begin
        at12 = (bus.done === 1'b1);
        oc   = bus.c;
        ob   = bus.borrow;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.c, bus.borrow, bus.busy, bus.done} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got c=%h borrow=%b busy=%b done=%b, want all 0",
               bus.c, bus.borrow, bus.busy, bus.done);
    end
    // Start held together with reset must not launch an operation.
    bus.start = 1'b1; bus.a = 12'h00A; bus.b = 12'h001;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vs_start: got busy=%b, want 0", bus.busy);
    end
  endtask

  task automatic test_vectors;
    logic [11:0] ta[6]  = '{12'd100, 12'd5, 12'hFFF, 12'h000, 12'h000, 12'h123};
    logic [11:0] tb_[6] = '{12'd37,  12'd9, 12'h001, 12'h000, 12'hFFF, 12'h023};
    logic [11:0] tc[6]  = '{12'h03F, 12'hFFC, 12'hFFE, 12'h000, 12'h001, 12'h100};
    logic        tr[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [11:0] oc;
    logic        ob;
    int          bn, dn;
    bit          st, a12;
    for (int i = 0; i < 6; i++) begin
      // Last vector is the operand-hold case: a/b scrambled every cycle after acceptance.
      run_op(ta[i], tb_[i], (i == 5), oc, ob, bn, dn, st, a12);
      n_checks++;
      if (oc !== exp_c(tc[i], tr[i]) || ob !== tr[i]) begin
        n_fail++;
        $display("FAIL vec%0d_result: %h-%h got c=%h borrow=%b, want c=%h borrow=%b",
                 i, ta[i], tb_[i], oc, ob, exp_c(tc[i], tr[i]), tr[i]);
      end
      n_checks++;
      if (bn != 12 || dn != 1 || !a12) begin
        n_fail++;
        $display("FAIL vec%0d_timing: got busy_cycles=%0d done_cycles=%0d done_at_E12=%0b, want 12 1 1",
                 i, bn, dn, a12);
      end
      n_checks++;
      if (!st) begin
        n_fail++;
        $display("FAIL vec%0d_c_hold: got c changing during RUN, want c stable until completion", i);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit saw_done;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 12'd200; bus.b = 12'd50;
    @(negedge clk);                  // now E+0.5
    bus.start = 1'b0;
    saw_done = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      // Rejected requests: edge E+5 (RUN) and edge E+13 (DONE).
      if (k == 5 || k == 13) begin
        bus.start = 1'b1; bus.a = 12'd7; bus.b = 12'd1;
      end else begin
        bus.start = 1'b0; bus.a = 12'd200; bus.b = 12'd50;
      end
      @(negedge clk);                // now E+k+0.5
      if (k == 12) saw_done = (bus.done === 1'b1) && (bus.c === 12'd150);
    end
    n_checks++;
    if (!saw_done) begin
      n_fail++;
      $display("FAIL b2b_first: got done/c not 1/150 at E+12 (c=%h), want done=1 c=096", bus.c);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.c !== 12'd150) begin
      n_fail++;
      $display("FAIL b2b_dropped: got busy=%b done=%b c=%h at E+13, want 0 0 096",
               bus.busy, bus.done, bus.c);
    end
    // Start still high for edge E+14: accepted as new operation.
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept_e14: got busy=%b, want 1", bus.busy);
    end
    repeat (11) @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.c !== 12'd150) begin
      n_fail++;
      $display("FAIL b2b_second_early: got done=%b c=%h at E'+11, want 0 096", bus.done, bus.c);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.c !== 12'd6 || bus.borrow !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: got done=%b c=%h borrow=%b at E'+12, want 1 006 0",
               bus.done, bus.c, bus.borrow);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    logic [11:0] oc;
    logic        ob;
    int          bn, dn;
    bit          st, a12;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 12'h800; bus.b = 12'h001;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);       // E+5.5: sixth RUN cycle
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got busy=%b, want 1", bus.busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.c, bus.borrow, bus.busy, bus.done} !== 15'h0) begin
      n_fail++;
      $display("FAIL midrst_async: got c=%h borrow=%b busy=%b done=%b, want all 0",
               bus.c, bus.borrow, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    n_checks++;
    if (bus.c !== 12'h000 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_aborted: got c=%h done=%b busy=%b, want 000 0 0",
               bus.c, bus.done, bus.busy);
    end
    run_op(12'd3, 12'd3, 1'b0, oc, ob, bn, dn, st, a12);
    n_checks++;
    if (oc !== 12'h000 || ob !== 1'b0 || !a12 || bn != 12) begin
      n_fail++;
      $display("FAIL midrst_fresh: got c=%h borrow=%b done_at_E12=%0b busy_cycles=%0d, want 000 0 1 12",
               oc, ob, a12, bn);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/twbit_serial_sub.md
# twbit_serial_sub

Sequential 12-bit bit-serial subtractor. It computes c = a − b one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It sits alongside the 12-bit combinational adder in the datapath arithmetic group and provides the subtract direction at minimum area. A start/busy/done handshake frames each operation, and a borrow flag reports underflow.

## Interface
- No parameters; the width is fixed at 12 bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a subtraction; sampled only in IDLE.
- a  input  12  minuend; captured on the accepting edge.
- b  input  12  subtrahend; captured on the accepting edge.
- c  output  12  registered difference a − b mod 4096; holds until the next completion.
- borrow  output  1  registered final borrow (1 when a < b unsigned); holds with c.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in the DONE state.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on a clk edge with start=1.
  - RUN → DONE after the 12th bit step.
  - DONE → IDLE unconditionally.
- Accepting edge:
  - a and b are loaded into shift registers sa and sb.
  - The internal borrow flop bw clears to 0.
  - The 4-bit bit counter clears to 0.
- Each RUN edge performs one bit step:
  - d = sa[0] ^ sb[0] ^ bw.
  - bw_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw).
  - sa and sb shift right by 1.
  - d shifts into the MSB of the result shift register sr.
  - The counter increments.
- The 12th step happens at counter = 11. On that edge:
  - c is loaded from {d, sr[11:1]}.
  - borrow is loaded from bw_next.
  - The state moves to DONE.
- c and borrow change only on that edge, so intermediate shift values are never visible on c.
- start is ignored in RUN and DONE. No queueing: a request during busy is dropped and must be re-issued.
- a and b may change freely after the accepting edge.
- Arithmetic is unsigned modulo 2^12. Signed callers interpret c as two's complement and derive overflow externally.

## Timing
- Reset value of every output: c=0x000, borrow=0, busy=0, done=0.
- Reset value of internal state: state=IDLE, counter=0, sa=sb=sr=0, bw=0.
- Reset is asynchronous and takes effect immediately, including mid-RUN. The operation is aborted and c keeps its reset value of 0 (it is not the partial result).
- Latency, with start accepted at edge E:
  - busy=1 from E to E+12.
  - done=1 and c/borrow valid from E+12.
  - done drops at E+13 and the FSM returns to IDLE.
- Throughput: one operation per 14 cycles. The earliest next accepting edge is E+14, because start must be seen in IDLE.
- Reset held across an edge with start=1 wins; no operation starts.

## Configuration
- Macro: TWBIT_SUB_SATURATE_EN.
- Defined: on the completion edge, if the final borrow is 1, c loads 0x000 instead of the wrapped difference. The borrow flag is still 1.
- Undefined: c always loads the wrapped modulo-4096 difference.
- Handshake, latency and the reset behaviour are identical in both builds.

## Test plan
- Basic subtract: a=100, b=37, start pulse.
  - busy for 12 cycles, then done pulse.
  - c=0x03F, borrow=0.
- Underflow: a=5, b=9.
  - Macro undefined: c=0xFFC, borrow=1.
  - Macro defined: c=0x000, borrow=1.
- Boundary values:
  - 0xFFF − 0x001 → c=0xFFE, borrow=0.
  - 0x000 − 0x000 → c=0x000, borrow=0.
  - 0x000 − 0xFFF → c=0x001, borrow=1 (c=0x000 with the macro defined).
- Busy rejection:
  - Start 200−50, then assert start with a=7, b=1 during RUN and during DONE.
  - Only c=150 is produced.
  - A new start at E+14 then yields c=6 at its own E+12.
- Reset mid-operation:
  - Assert rst at the 6th RUN cycle of 0x800−0x001.
  - Outputs immediately read c=0, borrow=0, busy=0, done=0.
  - After release, a fresh 3−3 completes with c=0 and done after 12 cycles.
- Operand hold: change a and b every cycle after acceptance of 0x123−0x023; the result is still c=0x100.
